// File: rtl/rect_fill_sequencer.sv
// Rectangle-fill / screen-clear sequencer that drives the VGA adapter write port, one pixel per clock.
// Optional RECT_FILL_CLIP_EN: suppress oPlot for pixels outside the visible screen.
module rect_fill_sequencer #(
  parameter int unsigned X_SCREEN_PIXELS = 160,
  parameter int unsigned Y_SCREEN_PIXELS = 120
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic       iCmdValid,
  output logic       oCmdReady,
  input  logic       iCmdClear,
  input  logic [7:0] iCmdX,
  input  logic [6:0] iCmdY,
  input  logic [7:0] iCmdW,
  input  logic [6:0] iCmdH,
  input  logic [2:0] iCmdColour,
  input  logic       iAbort,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [2:0] oColour,
  output logic       oPlot,
  output logic       oBusy,
  output logic       oDone
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t     state, state_next;
  logic [7:0] x_lat, w_lat, col, next_col;
  logic [6:0] y_lat, h_lat, row, next_row;
  logic [7:0] eff_x, eff_w;
  logic [6:0] eff_y, eff_h;
  logic [2:0] eff_colour;
  logic       eff_nonzero, accept, last_pix, go_done;
  logic [7:0] base_x, off_x, pix_x;
  logic [6:0] base_y, off_y, pix_y;
  logic       pix_on;

  assign accept = iCmdValid && (state == IDLE);

  always_comb begin
    if (iCmdClear) begin
      eff_x      = '0;
      eff_y      = '0;
      eff_w      = 8'(X_SCREEN_PIXELS);
      eff_h      = 7'(Y_SCREEN_PIXELS);
      eff_colour = '0;
    end else begin
      eff_x      = iCmdX;
      eff_y      = iCmdY;
      eff_w      = iCmdW;
      eff_h      = iCmdH;
      eff_colour = iCmdColour;
    end
    eff_nonzero = (eff_w != '0) && (eff_h != '0);
  end

  assign last_pix = (col == w_lat - 8'd1) && (row == h_lat - 7'd1);
  assign go_done  = iAbort || last_pix;

  always_comb begin
    if (col == w_lat - 8'd1) begin
      next_col = '0;
      next_row = row + 7'd1;
    end else begin
      next_col = col + 8'd1;
      next_row = row;
    end
  end

  // One adder pair serves both the first pixel (from the live command) and later pixels (from the latch).
  always_comb begin
    if (state == IDLE) begin
      base_x = eff_x;
      base_y = eff_y;
      off_x  = '0;
      off_y  = '0;
    end else begin
      base_x = x_lat;
      base_y = y_lat;
      off_x  = next_col;
      off_y  = next_row;
    end
    pix_x = base_x + off_x;
    pix_y = base_y + off_y;
  end

`ifdef RECT_FILL_CLIP_EN
  logic [8:0] wide_x;
  logic [7:0] wide_y;
  assign wide_x = {1'b0, base_x} + {1'b0, off_x};
  assign wide_y = {1'b0, base_y} + {1'b0, off_y};
  assign pix_on = (wide_x < 9'(X_SCREEN_PIXELS)) && (wide_y < 8'(Y_SCREEN_PIXELS));
`else
  assign pix_on = 1'b1;
`endif

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = eff_nonzero ? DRAW : DONE;
      DRAW:    if (go_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    oCmdReady = (state == IDLE);
    oBusy     = (state != IDLE);
    oDone     = (state == DONE);
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      x_lat   <= '0;
      y_lat   <= '0;
      w_lat   <= '0;
      h_lat   <= '0;
      col     <= '0;
      row     <= '0;
      oX      <= '0;
      oY      <= '0;
      oColour <= '0;
      oPlot   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_lat   <= eff_x;
            y_lat   <= eff_y;
            w_lat   <= eff_w;
            h_lat   <= eff_h;
            col     <= '0;
            row     <= '0;
            oColour <= eff_colour;
            if (eff_nonzero) begin
              oX    <= pix_x;
              oY    <= pix_y;
              oPlot <= pix_on;
            end
          end
        end
        DRAW: begin
          if (go_done) begin
            oPlot <= 1'b0;
          end else begin
            col   <= next_col;
            row   <= next_row;
            oX    <= pix_x;
            oY    <= pix_y;
            oPlot <= pix_on;
          end
        end
        default: oPlot <= 1'b0;
      endcase
    end
  end

endmodule
